// File: rtl/bcd2bin_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
// The optional invalid-digit check is enabled by defining BCD2BIN_DIGIT_CHECK_EN.
package bcd2bin_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of one BCD digit
    localparam int DIG_W = 4;

    // Reverse double dabble correction: a digit >= 8 after the shift gets 3 removed
    localparam logic [DIG_W-1:0] ADJ_THRESH = 4'd8;
    localparam logic [DIG_W-1:0] ADJ_OFFSET = 4'd3;

    // Largest legal BCD digit value, used by the optional input check
    localparam logic [DIG_W-1:0] DIG_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit correction for reverse double dabble: subtract 3 when the digit is >= 8.
// A legal digit is at most 12 after the shift, so the 4-bit subtraction never underflows.
module bcd_digit_adj
    import bcd2bin_pkg::*;
(
    input  logic [DIG_W-1:0] digit_in,
    output logic [DIG_W-1:0] digit_out
);

    // Conditional subtract of the correction offset
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= ADJ_THRESH) begin
            digit_out = digit_in - ADJ_OFFSET;
        end
    end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble, one bit per clock).
// Define BCD2BIN_DIGIT_CHECK_EN to flag digits above 9 through err and force bin to 0.
module bcd2bin_seq
    import bcd2bin_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       mil,
    input  logic [3:0]       cen,
    input  logic [3:0]       dez,
    input  logic [3:0]       und,
    output logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int BCD_W = NDIG * DIG_W;
    localparam int CNT_W = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_sr_q, bcd_sr_d;
    logic [BIN_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]   bcd_in;
    logic [BCD_W-1:0]   bcd_shift;
    logic [BIN_W-1:0]   work_shift;
    logic [BCD_W-1:0]   bcd_adj;

    assign bcd_in = BCD_W'({mil, cen, dez, und});

    // The BCD register and work register move as one long right shift
    assign {bcd_shift, work_shift} = {1'b0, bcd_sr_q, work_q[BIN_W-1:1]};

    genvar g;
    generate
        for (g = 0; g < NDIG; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit_in  (bcd_shift[g*DIG_W +: DIG_W]),
                .digit_out (bcd_adj[g*DIG_W +: DIG_W])
            );
        end
    endgenerate

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic flag_q, flag_d;
    logic err_q, err_d;
    logic bad_digit;

    // Any input digit above 9 makes the whole entry invalid
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_in[i*DIG_W +: DIG_W] > DIG_MAX) begin
                bad_digit = 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bcd_sr_q <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            bin_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            flag_q   <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            bcd_sr_q <= bcd_sr_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            flag_q   <= flag_d;
            err_q    <= err_d;
`endif
        end
    end

    // Next-state logic; the shift phase length is fixed by the counter
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output updates for each state
    always_comb begin
        bcd_sr_d = bcd_sr_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        flag_d   = flag_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    bcd_sr_d = bcd_in;
                    work_d   = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    flag_d   = bad_digit;
`endif
                end
            end
            SHIFT: begin
                bcd_sr_d = bcd_adj;
                work_d   = work_shift;
                cnt_d    = cnt_q + 1'b1;
                busy_d   = 1'b1;
            end
            DONE: begin
                bin_d  = work_q;
                done_d = 1'b1;
                busy_d = 1'b1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                err_d  = flag_q;
                if (flag_q) begin
                    bin_d = '0;
                end
`endif
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign bin  = bin_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed self-checking bench for bcd2bin_seq.
// Feature vectors for BCD2BIN_DIGIT_CHECK_EN run only when that macro is defined.
module tb_bcd2bin_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  mil, cen, dez, und;
    logic [13:0] bin;
    logic        busy, done, err;

    int checks;
    int errors;

    bcd2bin_seq #(.NDIG(4), .BIN_W(14)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mil   (mil),
        .cen   (cen),
        .dez   (dez),
        .und   (und),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Present digits with start for one edge; returns at the falling edge just after start was sampled
    task automatic applyStimulus(input logic [3:0] m, input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
        @(negedge clk);
        mil = m; cen = c; dez = d; und = u;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Full conversion: latency, result, error flag and the single-cycle done pulse
    task automatic runConversion(input string tag, input logic [3:0] m, input logic [3:0] c,
                                 input logic [3:0] d, input logic [3:0] u,
                                 input logic [13:0] exp_bin, input logic exp_err);
        int lat;
        lat = 0;
        applyStimulus(m, c, d, u);
        checkOutput({tag, "_busy_start"}, 32'(busy), 32'd1);
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'd15);
        checkOutput({tag, "_bin"}, 32'(bin), 32'(exp_bin));
        checkOutput({tag, "_err"}, 32'(err), 32'(exp_err));
        checkOutput({tag, "_busy_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, 32'(done), 32'd0);
        checkOutput({tag, "_busy_idle"}, 32'(busy), 32'd0);
        checkOutput({tag, "_bin_hold"}, 32'(bin), 32'(exp_bin));
    endtask

    // Wait until the converter is idle, bounded so a stuck design still reaches the summary
    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int done_cnt;
        int first_done;
        int last_done;
        logic busy_dropped;
        logic [13:0] seen_bin;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0;
        mil = 4'd0; cen = 4'd0; dez = 4'd0; und = 4'd0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_bin", 32'(bin), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);

        runConversion("d9999", 4'd9, 4'd9, 4'd9, 4'd9, 14'h270F, 1'b0);
        runConversion("d0000", 4'd0, 4'd0, 4'd0, 4'd0, 14'd0, 1'b0);
        runConversion("d1234", 4'd1, 4'd2, 4'd3, 4'd4, 14'h04D2, 1'b0);
        runConversion("d0007", 4'd0, 4'd0, 4'd0, 4'd7, 14'd7, 1'b0);
        runConversion("d0809", 4'd0, 4'd8, 4'd0, 4'd9, 14'd809, 1'b0);

        // A second start mid-conversion must be ignored
        done_cnt = 0;
        first_done = 0;
        busy_dropped = 1'b0;
        seen_bin = '0;
        applyStimulus(4'd5, 4'd0, 4'd0, 4'd0);
        for (int n = 1; n <= 35; n++) begin
            if (n == 5) begin
                mil = 4'd1; cen = 4'd1; dez = 4'd1; und = 4'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (n <= 15 && !busy) busy_dropped = 1'b1;
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = n;
                seen_bin = bin;
            end
        end
        checkOutput("ignore_done_count", 32'(done_cnt), 32'd1);
        checkOutput("ignore_latency", 32'(first_done), 32'd15);
        checkOutput("ignore_bin", 32'(seen_bin), 32'd5000);
        checkOutput("ignore_busy_held", 32'(busy_dropped), 32'd0);

        // Reset in the middle of a conversion discards it
        applyStimulus(4'd9, 4'd9, 4'd9, 4'd9);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_bin", 32'(bin), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        done_cnt = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        checkOutput("midrst_no_done", 32'(done_cnt), 32'd0);

`ifdef BCD2BIN_DIGIT_CHECK_EN
        runConversion("bad_1A00", 4'd1, 4'hA, 4'd0, 4'd0, 14'd0, 1'b1);
        runConversion("after_bad_0042", 4'd0, 4'd0, 4'd4, 4'd2, 14'd42, 1'b0);
`endif

        // Start held high: a new conversion every 16 cycles
        done_cnt = 0;
        first_done = 0;
        last_done = 0;
        busy_dropped = 1'b0;
        @(negedge clk);
        mil = 4'd0; cen = 4'd1; dez = 4'd0; und = 4'd0;
        start = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            @(negedge clk);
            if (n >= 2 && !busy) busy_dropped = 1'b1;
            if (done) begin
                done_cnt++;
                checkOutput("b2b_bin", 32'(bin), 32'd100);
                if (first_done == 0) begin
                    first_done = n;
                end else begin
                    checkOutput("b2b_interval", 32'(n - last_done), 32'd16);
                end
                last_done = n;
            end
        end
        start = 1'b0;
        checkOutput("b2b_first", 32'(first_done), 32'd16);
        checkOutput("b2b_count", 32'(done_cnt), 32'd4);
        checkOutput("b2b_busy_held", 32'(busy_dropped), 32'd0);
        waitIdle("b2b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
- Sequential BCD-to-binary converter; the inverse of the display path's binary-to-BCD stage.
- Takes four packed BCD digits (thousands, hundreds, tens, units) from switch/keypad entry logic on the Basys3.
- Produces a 14-bit binary value using reverse double dabble: shift right, then subtract 3 from any digit >= 8.
- Processes one bit per clock under a start/busy/done handshake.

Parameters:
- NDIG, 4, number of BCD digits.
- BIN_W, 14, binary result width; must satisfy 10^NDIG - 1 <= 2^BIN_W - 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request conversion; sampled only in IDLE.
- mil  in  4  thousands digit.
- cen  in  4  hundreds digit.
- dez  in  4  tens digit.
- und  in  4  units digit.
- bin  out  BIN_W  binary result, registered.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when bin is updated.
- err  out  1  invalid-digit flag, registered with done.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; bin=0, busy=0, done=0, err=0; internal shift registers and counter cleared. Reset overrides everything, including mid-conversion; a partial result is discarded.
- States:
  - IDLE: start=1 latches {mil,cen,dez,und} into a 16-bit BCD shift register, clears the BIN_W work register, sets cnt=0, sets busy=1, and moves to SHIFT.
  - SHIFT, each cycle:
    - Shift the concatenation {bcd_sr, work} right by 1.
    - Then, per digit, if the digit is >= 8, subtract 3 (combinational, same cycle).
    - cnt increments; when cnt reaches BIN_W-1, move to DONE.
  - DONE: bin <= work, done=1 for exactly this cycle, busy=0 on the next edge, return to IDLE.
- Latency:
  - start sampled at edge k.
  - SHIFT occupies edges k+1 .. k+BIN_W.
  - done=1 and bin valid during the cycle after edge k+BIN_W+1 (15 clocks after start for the defaults).
  - The latency is fixed and does not depend on the data.
- bin holds its last value until the next done. Inputs may change freely once start has been sampled.
- start while busy is ignored and not queued. start in the DONE cycle is ignored. start is accepted again once the block is back in IDLE.
- busy=1 from the cycle after start is sampled until the DONE cycle, inclusive. busy and done are both high in the DONE cycle.
- Counter width is clog2(BIN_W); it never wraps within a conversion.
- Digit adjustment uses 4-bit arithmetic. A valid digit after the shift is at most 12, so subtracting 3 never underflows.

Optional Feature:
- Macro: BCD2BIN_DIGIT_CHECK_EN.
- Defined:
  - At start, any digit > 9 sets an internal flag.
  - The conversion still runs for the full fixed latency.
  - In DONE: bin <= 0 and err=1 (err held until the next done).
- Undefined:
  - err is tied to 0.
  - Invalid digits yield whatever the algorithm produces, unchecked.
  - No comparators are synthesised.

Decomposition:
- Package bcd2bin_pkg contains:
  - state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the BCD digit width constant (4);
  - the adjustment threshold (8) and offset (3).
- One sub-module, bcd_digit_adj: combinational 4-bit "if >= 8 then -3", instantiated NDIG times in a generate loop.

Test Plan:
- rst, then start with digits 9,9,9,9 -> after 15 clocks done=1, bin=9999 (14'h270F), err=0.
- Digits 0,0,0,0 -> bin=0, done pulse exactly 1 cycle. Digits 1,2,3,4 -> bin=1234 (14'h04D2). Digits 0,0,0,7 -> bin=7.
- Start 5,0,0,0, then pulse start again at cycle 5 with 1,1,1,1 -> only one done, bin=5000; busy stays 1 throughout.
- Start 9,9,9,9, assert rst at cycle 7 -> next cycle busy=0, bin=0, done=0, no done pulse follows.
- With BCD2BIN_DIGIT_CHECK_EN: digits 1,A,0,0 -> done at 15 clocks, err=1, bin=0. A following valid 0,0,4,2 -> err=0, bin=42.
- Back-to-back: start held high continuously with 0,1,0,0 -> done every 16 cycles, each with bin=100.
